// File: rtl/kyber_pkg.sv
// -----------------------------------------------------------------------------
// kyber_pkg
// Shared Kyber512 sizing constants and the post-decryption controller state
// type. Imported by post_decryption and ct_compare_stream.
// -----------------------------------------------------------------------------
package kyber_pkg;

   localparam int unsigned KYBER_N  = 256;  // message / key / hash-half width
   localparam int unsigned KYBER_K  = 2;    // module rank (Kyber512)
   localparam int unsigned WORD_W   = 32;   // ciphertext stream word width
   localparam int unsigned CT_WORDS = 192;  // 768-byte ciphertext in words

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      G_REQ    = 3'd1,
      G_WAIT   = 3'd2,
      COIN_OUT = 3'd3,
      CMP      = 3'd4,
      DONE     = 3'd5
   } pd_state_e;

endpackage

// File: rtl/ct_compare_stream.sv
// -----------------------------------------------------------------------------
// ct_compare_stream
// Word-by-word equality check of two ciphertext streams. Counts accepted
// words, keeps a sticky match flag and raises done after CT_WORDS words;
// words offered after done are ignored.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   clear               restart: counter=0, match=1, done=0
//   en                  word pair valid this cycle
//   word_a, word_b      the two words being compared
//   match, done         registered status
//   match_nxt, done_nxt status as it will be after this clock edge
// -----------------------------------------------------------------------------
module ct_compare_stream #(
   parameter int unsigned WORD_W   = 32,
   parameter int unsigned CT_WORDS = 192
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              en,
   input  logic [WORD_W-1:0] word_a,
   input  logic [WORD_W-1:0] word_b,
   output logic              match,
   output logic              done,
   output logic              match_nxt,
   output logic              done_nxt
);

   localparam int unsigned CNT_W = $clog2(CT_WORDS + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             match_q, match_d;
   logic             done_q, done_d;

   always_comb begin
      cnt_d   = cnt_q;
      match_d = match_q;
      done_d  = done_q;
      if (clear) begin
         cnt_d   = '0;
         match_d = 1'b1;
         done_d  = 1'b0;
      end else if (en && !done_q) begin
         match_d = match_q & (word_a == word_b);
         cnt_d   = cnt_q + 1'b1;
         done_d  = (cnt_q == CNT_W'(CT_WORDS - 1));
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         match_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         match_q <= match_d;
         done_q  <= done_d;
      end
   end

   assign match     = match_q;
   assign done      = done_q;
   assign match_nxt = match_d;
   assign done_nxt  = done_d;

endmodule

// File: rtl/post_decryption.sv
// -----------------------------------------------------------------------------
// post_decryption
// Decapsulation post-stage: requests G(m'||H(ek)) from the SHA3-512 engine,
// hands r' to re-encryption as coins, compares received and re-encrypted
// ciphertext streams, and outputs K' on match or J(z||c) on mismatch.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   start / busy               begin (sampled in IDLE) / not idle
//   m_prime, h_ek              inputs captured on accepted start
//   g_req/g_in/g_ack           G request handshake, g_in = {h_ek, m_prime}
//   g_valid/g_out              G response pulse, {r', K'}
//   coin/coin_valid/coin_ready r' handoff to re-encryption
//   ct_valid/ct_word/ct_prime_word  ciphertext word pairs
//   j_req/j_valid/j_out        J(z||c) start pulse and response
//   shared_key/key_valid/reject     result (key and reject held)
// -----------------------------------------------------------------------------
module post_decryption
   import kyber_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 busy,
   input  logic [KYBER_N-1:0]   m_prime,
   input  logic [KYBER_N-1:0]   h_ek,
   output logic                 g_req,
   output logic [2*KYBER_N-1:0] g_in,
   input  logic                 g_ack,
   input  logic                 g_valid,
   input  logic [2*KYBER_N-1:0] g_out,
   output logic [KYBER_N-1:0]   coin,
   output logic                 coin_valid,
   input  logic                 coin_ready,
   input  logic                 ct_valid,
   input  logic [WORD_W-1:0]    ct_word,
   input  logic [WORD_W-1:0]    ct_prime_word,
   output logic                 j_req,
   input  logic                 j_valid,
   input  logic [KYBER_N-1:0]   j_out,
   output logic [KYBER_N-1:0]   shared_key,
   output logic                 key_valid,
   output logic                 reject
);

   pd_state_e state_q, state_d;

   logic [KYBER_N-1:0] m_q, h_q, kp_q, coin_q, kbar_q, kbar_d, key_q;
   logic               j_done_q, j_done_d, j_req_q, reject_q;
   logic               accept, cmp_clear, cmp_en, j_take;
   logic               cmp_match, cmp_done, match_nxt, done_nxt;

   assign accept    = (state_q == IDLE) && start;
   assign cmp_clear = (state_q == COIN_OUT) && coin_ready;
   assign cmp_en    = (state_q == CMP) && ct_valid;
   assign j_take    = (state_q == CMP) && j_valid && !j_done_q;

   ct_compare_stream #(
      .WORD_W   (WORD_W),
      .CT_WORDS (CT_WORDS)
   ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (cmp_clear),
      .en        (cmp_en),
      .word_a    (ct_word),
      .word_b    (ct_prime_word),
      .match     (cmp_match),
      .done      (cmp_done),
      .match_nxt (match_nxt),
      .done_nxt  (done_nxt)
   );

   // J latch: first j_valid in CMP wins, cleared on each accepted start.
   always_comb begin
      j_done_d = j_done_q;
      kbar_d   = kbar_q;
      if (accept) begin
         j_done_d = 1'b0;
         kbar_d   = '0;
      end else if (j_take) begin
         j_done_d = 1'b1;
         kbar_d   = j_out;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (start)      state_d = G_REQ;
         G_REQ:    if (g_ack)      state_d = G_WAIT;
         G_WAIT:   if (g_valid)    state_d = COIN_OUT;
         COIN_OUT: if (coin_ready) state_d = CMP;
         // Look ahead on both completions so DONE follows the later event
         // by exactly one cycle, even when both land in the same cycle.
         CMP:      if (done_nxt && j_done_d) state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         m_q      <= '0;
         h_q      <= '0;
         kp_q     <= '0;
         coin_q   <= '0;
         kbar_q   <= '0;
         key_q    <= '0;
         j_done_q <= 1'b0;
         j_req_q  <= 1'b0;
         reject_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         j_done_q <= j_done_d;
         kbar_q   <= kbar_d;
         j_req_q  <= cmp_clear;
         if (accept) begin
            m_q      <= m_prime;
            h_q      <= h_ek;
            key_q    <= '0;
            reject_q <= 1'b0;
         end
         if ((state_q == G_WAIT) && g_valid) begin
            kp_q   <= g_out[KYBER_N-1:0];
            coin_q <= g_out[2*KYBER_N-1:KYBER_N];
         end
         if ((state_q == CMP) && (state_d == DONE)) begin
            key_q    <= match_nxt ? kp_q : kbar_d;
            reject_q <= ~match_nxt;
         end
      end
   end

   assign busy       = (state_q != IDLE);
   assign g_req      = (state_q == G_REQ);
   assign g_in       = {h_q, m_q};
   assign coin       = coin_q;
   assign coin_valid = (state_q == COIN_OUT);
   assign j_req      = j_req_q;
   assign key_valid  = (state_q == DONE);
   assign shared_key = key_q;
   assign reject     = reject_q;

   // Registered status is unused by the controller; keep it observable.
   logic unused_status;
   assign unused_status = cmp_match ^ cmp_done;

endmodule

// File: tb/tb_post_decryption.sv
// -----------------------------------------------------------------------------
// tb_post_decryption
// Self-checking bench for post_decryption: expected results are queued when a
// run is launched and popped when key_valid appears.
// -----------------------------------------------------------------------------
module tb_post_decryption;
   import kyber_pkg::*;

   localparam int NW = int'(CT_WORDS);

   typedef logic [575:0] w_t;
   typedef struct packed {
      logic [KYBER_N-1:0] key;
      logic               rej;
      logic [KYBER_N-1:0] coin;
   } exp_t;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 start;
   logic                 busy;
   logic [KYBER_N-1:0]   m_prime, h_ek;
   logic                 g_req;
   logic [2*KYBER_N-1:0] g_in;
   logic                 g_ack, g_valid;
   logic [2*KYBER_N-1:0] g_out;
   logic [KYBER_N-1:0]   coin;
   logic                 coin_valid, coin_ready;
   logic                 ct_valid;
   logic [WORD_W-1:0]    ct_word, ct_prime_word;
   logic                 j_req, j_valid;
   logic [KYBER_N-1:0]   j_out;
   logic [KYBER_N-1:0]   shared_key;
   logic                 key_valid, reject;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   post_decryption dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy),
      .m_prime(m_prime), .h_ek(h_ek),
      .g_req(g_req), .g_in(g_in), .g_ack(g_ack),
      .g_valid(g_valid), .g_out(g_out),
      .coin(coin), .coin_valid(coin_valid), .coin_ready(coin_ready),
      .ct_valid(ct_valid), .ct_word(ct_word), .ct_prime_word(ct_prime_word),
      .j_req(j_req), .j_valid(j_valid), .j_out(j_out),
      .shared_key(shared_key), .key_valid(key_valid), .reject(reject)
   );

   task automatic check_eq(input string tag, input w_t obs, input w_t exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete decapsulation post-stage with configurable handshakes.
   // j_mode: 0 = J before first word, 1 = with last word, 2 = after compare.
   task automatic run_op(input logic [KYBER_N-1:0] m, input logic [KYBER_N-1:0] h,
                         input logic [KYBER_N-1:0] kp, input logic [KYBER_N-1:0] cn,
                         input logic [KYBER_N-1:0] kb, input int mis_idx,
                         input int ack_dly, input int coin_dly, input bit gap,
                         input int j_mode, input bit busy_start);
      exp_t e;
      int   widx = 0;
      int   cyc  = 0;
      int   post = 0;
      bit   j_sent = 1'b0;
      bit   kv_early = 1'b0;
      bit   word_now;

      @(negedge clk);
      m_prime = m; h_ek = h; start = 1'b1;
      e.key  = (mis_idx >= 0) ? kb : kp;
      e.rej  = (mis_idx >= 0);
      e.coin = cn;
      sb_q.push_back(e);
      @(negedge clk);
      start = 1'b0; m_prime = ~m; h_ek = ~h;
      check_eq("busy_after_start", w_t'(busy), w_t'(1));
      check_eq("key_cleared", w_t'({reject, shared_key}), '0);
      check_eq("g_req_g_in", w_t'({g_req, g_in}), w_t'({1'b1, h, m}));

      for (int i = 0; i < ack_dly; i++) begin
         @(negedge clk);
         check_eq("g_hold", w_t'({g_req, g_in}), w_t'({1'b1, h, m}));
      end
      g_ack = 1'b1;
      @(negedge clk);
      g_ack = 1'b0;
      check_eq("g_req_drop", w_t'(g_req), '0);

      if (busy_start) begin
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check_eq("g_in_kept_gwait", w_t'(g_in), w_t'({h, m}));
      end

      g_valid = 1'b1; g_out = {cn, kp};
      @(negedge clk);
      g_valid = 1'b0; g_out = {16{$urandom}};

      for (int i = 0; i < coin_dly; i++) begin
         ct_valid = 1'b1; ct_word = 32'h1; ct_prime_word = 32'h2;
         check_eq("coin_hold", w_t'({coin_valid, coin}), w_t'({1'b1, cn}));
         @(negedge clk);
      end
      ct_valid = 1'b0;
      check_eq("coin_out", w_t'({coin_valid, coin}), w_t'({1'b1, cn}));
      coin_ready = 1'b1;
      @(negedge clk);
      coin_ready = 1'b0;
      check_eq("coin_hs_jreq", w_t'({coin_valid, j_req, coin}), w_t'({1'b0, 1'b1, cn}));

      while (widx < NW || !j_sent) begin
         kv_early = kv_early | key_valid;
         if (cyc == 1) check_eq("j_req_pulse", w_t'(j_req), '0);
         ct_valid = 1'b0; j_valid = 1'b0; start = 1'b0;
         ct_word = 32'h0000_0001; ct_prime_word = 32'h0000_0000;
         word_now = (widx < NW) && !(j_mode == 0 && cyc == 0) && (!gap || (cyc % 2) == 1);
         if (j_mode == 0 && cyc == 0) begin
            j_valid = 1'b1; j_out = kb; j_sent = 1'b1;
         end else if (j_mode == 0 && cyc == 5) begin
            j_valid = 1'b1; j_out = ~kb;
         end
         if (word_now) begin
            ct_valid = 1'b1;
            ct_word  = $urandom;
            ct_prime_word = (widx == mis_idx) ? (ct_word ^ 32'h0000_0100) : ct_word;
            widx++;
            if (j_mode == 1 && widx == NW) begin
               j_valid = 1'b1; j_out = kb; j_sent = 1'b1;
            end
         end else if (widx == NW && j_mode == 2) begin
            ct_valid = 1'b1;
            if (post == 3) begin
               j_valid = 1'b1; j_out = kb; j_sent = 1'b1;
            end
            post++;
         end
         if (busy_start && cyc == 3) begin
            start = 1'b1; m_prime = ~m;
         end
         cyc++;
         @(negedge clk);
      end
      ct_valid = 1'b0; j_valid = 1'b0; start = 1'b0;

      check_eq("key_valid_early", w_t'(kv_early), '0);
      check_eq("key_valid", w_t'(key_valid), w_t'(1));
      if (sb_q.size() == 0) begin
         check_eq("sb_underflow", w_t'(1), '0);
      end else begin
         e = sb_q.pop_front();
         check_eq("shared_key", w_t'(shared_key), w_t'(e.key));
         check_eq("reject", w_t'(reject), w_t'(e.rej));
         check_eq("coin_final", w_t'(coin), w_t'(e.coin));
      end
      if (busy_start) check_eq("g_in_kept_cmp", w_t'(g_in), w_t'({h, m}));
      @(negedge clk);
      check_eq("kv_single_idle", w_t'({key_valid, busy}), '0);
      check_eq("key_hold", w_t'({reject, shared_key}), w_t'({e.rej, e.key}));
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [KYBER_N-1:0] m0, h0, kp0, cn0, kb0;
      m0  = 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20;
      h0  = {32{8'hAA}};
      cn0 = {32{8'hC0}};
      kp0 = {32{8'hB0}};
      kb0 = {8{32'hDEADBEEF}};

      rst_n = 1'b0; start = 1'b0; m_prime = '0; h_ek = '0;
      g_ack = 1'b0; g_valid = 1'b0; g_out = '0; coin_ready = 1'b0;
      ct_valid = 1'b0; ct_word = '0; ct_prime_word = '0; j_valid = 1'b0; j_out = '0;
      repeat (3) @(negedge clk);
      check_eq("reset_ctrl", w_t'({busy, g_req, coin_valid, j_req, key_valid, reject}), '0);
      check_eq("reset_data", w_t'({g_in, coin, shared_key}) , '0);
      rst_n = 1'b1;

      // match, J after compare
      run_op(m0, h0, kp0, cn0, kb0, -1, 0, 0, 1'b0, 2, 1'b0);
      // mismatch on last word, J with the last word
      run_op(m0, h0, kp0, cn0, kb0, NW-1, 0, 0, 1'b0, 1, 1'b0);
      // match, J before first word, start pulses while busy
      run_op(m0, h0, kp0, cn0, kb0, -1, 0, 0, 1'b0, 0, 1'b1);
      // backpressure with mismatch mid-stream
      run_op(~m0, h0 ^ {8{32'h1234_5678}}, {8{32'h0BADF00D}}, {8{32'hC0FFEE00}},
             kb0, 50, 5, 7, 1'b1, 2, 1'b0);

      // reset in the middle of the compare stream
      @(negedge clk);
      m_prime = m0; h_ek = h0; start = 1'b1;
      @(negedge clk); start = 1'b0; g_ack = 1'b1;
      @(negedge clk); g_ack = 1'b0; g_valid = 1'b1; g_out = {cn0, kp0};
      @(negedge clk); g_valid = 1'b0; coin_ready = 1'b1;
      @(negedge clk); coin_ready = 1'b0;
      for (int i = 0; i < 100; i++) begin
         ct_valid = 1'b1; ct_word = $urandom; ct_prime_word = ct_word;
         @(negedge clk);
      end
      ct_valid = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_eq("midrst_ctrl", w_t'({busy, g_req, coin_valid, j_req, key_valid, reject}), '0);
      check_eq("midrst_data", w_t'({g_in, coin, shared_key}), '0);
      g_valid = 1'b1; g_out = {cn0, kp0}; j_valid = 1'b1; j_out = kb0;
      ct_valid = 1'b1; ct_word = 32'h5; ct_prime_word = 32'h6;
      @(negedge clk);
      g_valid = 1'b0; j_valid = 1'b0; ct_valid = 1'b0;
      repeat (2) @(negedge clk);
      check_eq("stray_ignored", w_t'({busy, coin_valid, key_valid, reject, coin, shared_key}), '0);

      // normal run after reset, J with last word
      run_op(h0, m0, {8{32'h13579BDF}}, {8{32'h2468ACE0}}, {8{32'hFEEDFACE}},
             -1, 1, 2, 1'b0, 1, 1'b0);

      check_eq("sb_empty", w_t'(sb_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
